// File: rtl/video_mode_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : video_mode_detect_if
// Summary  : Raster inputs and published-mode outputs of video_mode_detect.
// Revision : 1.0 - initial release
// ============================================================================
interface video_mode_detect_if;
  logic        CE_PIXEL;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_DE;
  logic [11:0] HSIZE;
  logic [11:0] VSIZE;
  logic [11:0] HTOTAL;
  logic [11:0] VTOTAL;
  logic        STABLE;
  logic        CHANGED;

  modport master (
    output CE_PIXEL, VGA_HS, VGA_VS, VGA_DE,
    input  HSIZE, VSIZE, HTOTAL, VTOTAL, STABLE, CHANGED
  );

  modport slave (
    input  CE_PIXEL, VGA_HS, VGA_VS, VGA_DE,
    output HSIZE, VSIZE, HTOTAL, VTOTAL, STABLE, CHANGED
  );
endinterface
`default_nettype wire

// File: rtl/video_mode_detect.sv
`default_nettype none
// ============================================================================
// Module   : video_mode_detect
// Summary  : Measures the video raster and publishes it once stable for
//            STABLE_FRAMES consecutive frames.
// Revision : 1.0 - initial release
// ============================================================================
module video_mode_detect #(
  parameter int STABLE_FRAMES = 4,
  parameter int TIMEOUT_BITS  = 24
) (
  input  wire logic          CLK_VIDEO,
  input  wire logic          RESET,
  video_mode_detect_if.slave vid
);

  localparam logic [11:0]             c_cnt_max  = 12'hFFF;
  localparam logic [3:0]              c_frames   = 4'(STABLE_FRAMES);
  localparam logic [TIMEOUT_BITS-1:0] c_wd_one   = TIMEOUT_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] c_wd_max   = {TIMEOUT_BITS{1'b1}};
  localparam logic [TIMEOUT_BITS-1:0] c_wd_near  = c_wd_max - c_wd_one;
  localparam logic [1:0]              c_idle     = 2'd0;
  localparam logic [1:0]              c_track    = 2'd1;
  localparam logic [1:0]              c_locked   = 2'd2;

  logic                    r_ce, r_hs, r_vs, r_de;
  logic                    r_old_hs, r_old_vs;
  logic [11:0]             r_htot, r_hact, r_line_max, r_ht_last, r_vact, r_vtot;
  logic                    r_armed;
  logic [47:0]             r_meas;
  logic                    r_meas_vld;
  logic [TIMEOUT_BITS-1:0] r_wd;

  logic [1:0]  r_state, w_state_n;
  logic [47:0] r_cand, w_cand_n;
  logic [3:0]  r_match, w_match_n;
  logic        r_stable, w_stable_n;
  logic        r_changed, w_publish;
  logic [11:0] r_hsize, r_vsize, r_htotal, r_vtotal;

  logic        w_line_ev, w_frame_ev, w_timeout, w_meas_ok, w_same;
  logic [11:0] w_line_max_n, w_ht_last_n, w_vact_n, w_vtot_n;

  function automatic logic [11:0] f_sat_inc(input logic [11:0] v);
    return (v == c_cnt_max) ? v : v + 12'd1;
  endfunction

  // Raster inputs pass through one register stage; events are detected there.
  assign w_line_ev  = r_ce & r_hs & ~r_old_hs;
  assign w_frame_ev = r_ce & r_vs & ~r_old_vs;
  assign w_timeout  = (r_wd >= c_wd_near) & ~w_frame_ev;

  // Values after a coincident line event, so a frame event can include them.
  always_comb begin
    w_line_max_n = r_line_max;
    w_ht_last_n  = r_ht_last;
    w_vact_n     = r_vact;
    w_vtot_n     = r_vtot;
    if (w_line_ev) begin
      if (r_hact > r_line_max) w_line_max_n = r_hact;
      w_ht_last_n = r_htot;
      if (r_hact != 12'd0) w_vact_n = f_sat_inc(r_vact);
      w_vtot_n = f_sat_inc(r_vtot);
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      r_ce       <= 1'b0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      r_de       <= 1'b0;
      r_old_hs   <= 1'b0;
      r_old_vs   <= 1'b0;
      r_htot     <= 12'd0;
      r_hact     <= 12'd0;
      r_line_max <= 12'd0;
      r_ht_last  <= 12'd0;
      r_vact     <= 12'd0;
      r_vtot     <= 12'd0;
      r_armed    <= 1'b0;
      r_meas     <= 48'd0;
      r_meas_vld <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_ce       <= vid.CE_PIXEL;
      r_hs       <= vid.VGA_HS;
      r_vs       <= vid.VGA_VS;
      r_de       <= vid.VGA_DE;
      r_meas_vld <= 1'b0;

      if (w_frame_ev)          r_wd <= '0;
      else if (r_wd != c_wd_max) r_wd <= r_wd + c_wd_one;

      if (r_ce) begin
        r_old_hs <= r_hs;
        r_old_vs <= r_vs;
      end

      if (w_timeout) begin
        r_armed    <= 1'b0;
        r_htot     <= 12'd0;
        r_hact     <= 12'd0;
        r_line_max <= 12'd0;
        r_ht_last  <= 12'd0;
        r_vact     <= 12'd0;
        r_vtot     <= 12'd0;
      end else if (r_ce) begin
        if (w_line_ev) begin
          r_htot <= 12'd1;
          r_hact <= {11'd0, r_de};
        end else begin
          r_htot <= f_sat_inc(r_htot);
          if (r_de) r_hact <= f_sat_inc(r_hact);
        end
        r_line_max <= w_line_max_n;
        r_ht_last  <= w_ht_last_n;
        r_vact     <= w_vact_n;
        r_vtot     <= w_vtot_n;
        if (w_frame_ev) begin
          r_meas     <= {w_line_max_n, w_vact_n, w_ht_last_n, w_vtot_n};
          r_meas_vld <= r_armed;
          r_armed    <= 1'b1;
          r_line_max <= 12'd0;
          r_vact     <= 12'd0;
          r_vtot     <= 12'd0;
        end
      end
    end
  end

  assign w_meas_ok = (r_meas[47:36] != 12'd0) && (r_meas[35:24] != 12'd0);
  assign w_same    = (r_meas == r_cand);

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      r_state   <= c_idle;
      r_cand    <= 48'd0;
      r_match   <= 4'd0;
      r_stable  <= 1'b0;
      r_changed <= 1'b0;
      r_hsize   <= 12'd0;
      r_vsize   <= 12'd0;
      r_htotal  <= 12'd0;
      r_vtotal  <= 12'd0;
    end else begin
      r_state   <= w_state_n;
      r_cand    <= w_cand_n;
      r_match   <= w_match_n;
      r_stable  <= w_stable_n;
      r_changed <= w_publish;
      if (w_publish) {r_hsize, r_vsize, r_htotal, r_vtotal} <= w_cand_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_timeout) begin
      w_state_n = c_idle;
    end else if (r_meas_vld) begin
      if (!w_meas_ok) begin
        w_state_n = c_idle;
      end else begin
        case (r_state)
          c_idle, c_track: w_state_n = w_publish ? c_locked : c_track;
          c_locked:        if (!w_same) w_state_n = w_publish ? c_locked : c_track;
          default:         w_state_n = c_idle;
        endcase
      end
    end
  end

  always_comb begin
    w_cand_n   = r_cand;
    w_match_n  = r_match;
    w_stable_n = r_stable;
    w_publish  = 1'b0;
    if (w_timeout) begin
      w_stable_n = 1'b0;
    end else if (r_meas_vld) begin
      if (!w_meas_ok) begin
        w_cand_n   = 48'd0;
        w_match_n  = 4'd0;
        w_stable_n = 1'b0;
      end else begin
        case (r_state)
          c_track: begin
            if (w_same) begin
              if (r_match != 4'hF) w_match_n = r_match + 4'd1;
            end else begin
              w_cand_n  = r_meas;
              w_match_n = 4'd1;
            end
          end
          c_locked: begin
            if (!w_same) begin
              w_stable_n = 1'b0;
              w_cand_n   = r_meas;
              w_match_n  = 4'd1;
            end
          end
          default: begin
            w_cand_n  = r_meas;
            w_match_n = 4'd1;
          end
        endcase
        // A locked mode that still matches must not republish.
        if ((w_match_n == c_frames) && !((r_state == c_locked) && w_same)) begin
          w_publish  = 1'b1;
          w_stable_n = 1'b1;
        end
      end
    end
  end

  assign vid.HSIZE   = r_hsize;
  assign vid.VSIZE   = r_vsize;
  assign vid.HTOTAL  = r_htotal;
  assign vid.VTOTAL  = r_vtotal;
  assign vid.STABLE  = r_stable;
  assign vid.CHANGED = r_changed;

endmodule
`default_nettype wire

// File: doc/video_mode_detect.md
# video_mode_detect

Measures the incoming core video raster (active width and height, total pixels per line, total lines per frame) and publishes a mode only after it has been identical for a configurable number of frames. It sits directly upstream of the crop / aspect / integer-scale stage. Its HSIZE/VSIZE drive that stage's scaling arithmetic, and its CHANGED pulse tells downstream logic to restart calculation. Measurement is qualified by CE_PIXEL, so it works at any pixel clock divider.

## Interface
Parameters:
- STABLE_FRAMES, 4: consecutive identical complete frames required before publishing. Range 1..15.
- TIMEOUT_BITS, 24: width of the no-VSync watchdog counter, in CLK_VIDEO cycles.

Ports:
- CLK_VIDEO  in  1  video clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- CE_PIXEL  in  1  pixel enable; all raster inputs are sampled only when high.
- VGA_HS  in  1  horizontal sync, active high.
- VGA_VS  in  1  vertical sync, active high.
- VGA_DE  in  1  active-video enable.
- HSIZE  out  12  published active pixels per line.
- VSIZE  out  12  published active lines per frame.
- HTOTAL  out  12  published CE_PIXEL count per line.
- VTOTAL  out  12  published lines per frame.
- STABLE  out  1  a published mode is current and still matching.
- CHANGED  out  1  one-CLK_VIDEO pulse when new values are published.

## Operation
- Edge detection: old_hs, old_vs and old_de update only on CE_PIXEL cycles.
  - A line event is a rising VGA_HS seen on a CE cycle.
  - A frame event is a rising VGA_VS seen on a CE cycle.
- Per-line counters:
  - htot_cnt increments on every CE cycle.
  - hact_cnt increments on CE cycles with VGA_DE=1.
- Line event handling:
  - line_max <= max(line_max, hact_cnt); ht_last <= htot_cnt.
  - If hact_cnt≠0, vact_cnt is incremented.
  - vtot_cnt is incremented.
  - htot_cnt and hact_cnt restart: each is set to 1 if the current CE pixel counts toward it, otherwise 0. The pixel at the event therefore belongs to the new line.
- Frame event handling: meas = {line_max, vact_cnt, ht_last, vtot_cnt} is latched, then line_max, vact_cnt and vtot_cnt are cleared.
  - A line event on the same CE cycle is processed first, and its contributions are included in meas.
- Saturation: all counters saturate at 4095 and never wrap.
- Startup: the first frame event after reset or after a timeout only arms the block (armed<=1) and discards the partial frame.
- Stability FSM, states IDLE / TRACK / LOCKED, evaluated one clock after each armed frame event:
  - Invalid meas: if width or height of meas is 0, candidate is cleared, match_cnt<=0, STABLE<=0, state goes to IDLE.
  - IDLE: candidate<=meas, match_cnt<=1, state goes to TRACK.
  - TRACK:
    - meas==candidate: match_cnt++, saturating.
    - Otherwise: candidate<=meas, match_cnt<=1.
    - When match_cnt reaches STABLE_FRAMES: publish candidate to HSIZE/VSIZE/HTOTAL/VTOTAL, STABLE<=1, CHANGED pulses, state goes to LOCKED.
  - LOCKED:
    - meas==candidate: no action.
    - Otherwise: STABLE<=0, candidate<=meas, match_cnt<=1, state goes to TRACK.
  - The published outputs hold their old values until the next publish.
- Watchdog:
  - Counts CLK_VIDEO cycles since the last frame event and clears on each frame event.
  - At all-ones: STABLE<=0, armed<=0, state goes to IDLE, all line and frame counters clear. Published outputs hold their values.
- Reset:
  - All outputs go to 0 and the state goes to IDLE with armed=0.
  - Reset in the middle of a frame discards all counts, and the next frame event only arms.

## Timing
- Let N be the clock edge on which a CE cycle with a rising VGA_VS is sampled.
  - meas is registered at N+1.
  - FSM results (outputs, STABLE, CHANGED) are visible after edge N+2.
- CHANGED is high for exactly one CLK_VIDEO cycle, the same cycle in which the new HSIZE/VSIZE are first visible.
- STABLE falls in the same cycle as the comparison fails: N+2.
- When CE_PIXEL=0, all raster state holds. The FSM and watchdog still run on every clock.
- With STABLE_FRAMES=1, any valid frame that differs from the published mode republishes on its own frame event.

## Test plan
- 256 active × 224 active lines, 341×262 total, CE every 4th clock, STABLE_FRAMES=4:
  - Frame events 1–4 → STABLE=0.
  - Frame event 5, at N+2 → HSIZE=256, VSIZE=224, HTOTAL=341, VTOTAL=262, STABLE=1, single CHANGED pulse.
  - 10 more identical frames → no further CHANGED pulses.
- While locked, switch to 320×240 in 400×262:
  - First differing frame → STABLE=0, outputs stay 256/224/341/262.
  - Four frames later → 320/240/400/262 published with CHANGED.
- Alternate 224- and 225-line frames → STABLE never asserts and CHANGED never pulses.
- Hold VGA_DE=0 for a whole frame while locked → STABLE=0, outputs hold. Restore the original mode → republish after 4 frames.
- TIMEOUT_BITS=8, stop VGA_VS → STABLE falls 255 clocks after the last frame event. Restart → the first frame event only arms, and publish happens at frame event 5.
- Assert RESET mid-frame while locked → next cycle all outputs are 0 and STABLE=0. Resumed video publishes at frame event 5. Coincident HS/VS rise on the same CE → that line is counted in the closing frame (VTOTAL=262, not 261).
